// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// A two-flop synchronizer cleans the asynchronous Rx pin. A five-state FSM
// centres its samples in each bit cell. Received bytes land in the FIFO, and
// sticky overrun/frame-error flags plus a per-byte interrupt pulse are reported.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Rx,
    input  logic       rd,
    input  logic       clr,
    output logic [7:0] data,
    output logic       valid,
    output logic       full,
    output logic       overrun,
    output logic       frame_err,
    output logic       intr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } rx_state_t;

    // Synchronizer flops (idle-high line)
    logic rx_meta_r;
    logic rx_sync_r;

    // Receiver FSM state
    rx_state_t        state_r, state_s;
    logic [CNT_W-1:0] cnt_r,   cnt_s;
    logic [2:0]       idx_r,   idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             push_s;
    logic             ferr_set_s;

    // FIFO storage and bookkeeping
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
    logic [OCC_W-1:0] occ_r,    occ_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             ovr_set_s;
    logic [7:0]       head_s;

    // Registered outputs
    logic [7:0] data_r;
    logic       valid_r;
    logic       full_r;
    logic       overrun_r;
    logic       frame_err_r;
    logic       intr_r;

    assign data      = data_r;
    assign valid     = valid_r;
    assign full      = full_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;
    assign intr      = intr_r;

    // Two-flop synchronizer for the asynchronous Rx pin
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= Rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receiver FSM state, bit-timing counter, bit index and shift register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
        end
    end

    // Receiver next-state: half-bit start qualification, mid-bit sampling, stop check
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        shift_s    = shift_r;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (!rx_sync_r) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = '0;
                    idx_s = 3'd0;
                    if (!rx_sync_r) begin
                        state_s = ST_DATA;
                    end else begin
                        // Too short to be a start bit: treat as a glitch
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s   = '0;
                    shift_s = {rx_sync_r, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s = '0;
                    if (rx_sync_r) begin
                        push_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        ferr_set_s = 1'b1;
                        state_s    = ST_BRK;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_BRK: begin
                // A held-low line must go high before another frame may start
                cnt_s = '0;
                if (rx_sync_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BRK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                idx_s   = 3'd0;
            end
        endcase
    end

    // FIFO next-state: pop/push arbitration, pointers, occupancy and next head byte
    always_comb begin
        pop_s     = rd && (occ_r != '0);
        push_ok_s = push_s && ((occ_r != OCC_FULL) || pop_s);
        ovr_set_s = push_s && (occ_r == OCC_FULL) && !pop_s;
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        occ_s     = occ_r;
        if (push_ok_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_s})
            2'b10:   occ_s = occ_r + OCC_ONE;
            2'b01:   occ_s = occ_r - OCC_ONE;
            default: occ_s = occ_r;
        endcase
        // Bypass the byte being written when it becomes the head in the same edge
        if (push_ok_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = shift_r;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // FIFO storage, pointers and head/valid/full/interrupt output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
            data_r   <= 8'h00;
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
            intr_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= shift_r;
            end
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            occ_r    <= occ_s;
            data_r   <= head_s;
            valid_r  <= (occ_s != '0);
            full_r   <= (occ_s == OCC_FULL);
            intr_r   <= push_ok_s;
        end
    end

    // Sticky error flags: a set event in the same cycle as clr keeps the flag set
    always_ff @(posedge CLK) begin
        if (RST) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (clr) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int BOUND = 2 + CPB / 2 + 9 * CPB + 3;
    // Negedges from the start-bit falling edge to the stop-sample edge's preceding negedge
    localparam int PUSH_NEG = 9 * CPB + CPB / 2 + 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Rx  = 1'b1;
    logic       rd  = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       full;
    logic       overrun;
    logic       frame_err;
    logic       intr;

    int n_checks = 0;
    int n_pass   = 0;
    int intr_cnt = 0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Rx       (Rx),
        .rd       (rd),
        .clr      (clr),
        .data     (data),
        .valid    (valid),
        .full     (full),
        .overrun  (overrun),
        .frame_err(frame_err),
        .intr     (intr)
    );

    always #5 CLK = ~CLK;

    // Count every cycle intr is high
    always @(posedge CLK) begin
        if (intr === 1'b1) intr_cnt <= intr_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        Rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            cycles(CPB);
        end
        Rx = stop_bit;
        cycles(CPB);
    endtask

    task automatic pop();
        rd = 1'b1;
        cycles(1);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"},     32'(valid),     32'd0);
        check_val({tag, "_full"},      32'(full),      32'd0);
        check_val({tag, "_overrun"},   32'(overrun),   32'd0);
        check_val({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check_val({tag, "_intr"},      32'(intr),      32'd0);
        check_val({tag, "_data"},      32'(data),      32'h00);
    endtask

    initial begin
        int          n;
        int          base;
        logic [7:0]  exp_q [$];

        // Reset state
        RST = 1'b1;
        cycles(3);
        check_reset_state("rst");
        RST = 1'b0;
        cycles(2);

        // Single byte 0xA5 with latency bound
        base = intr_cnt;
        n    = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while ((valid !== 1'b1) && (n < BOUND + 2)) begin
                    cycles(1);
                    n++;
                end
            end
        join
        check_val("a5_latency_in_bound", 32'(n <= BOUND), 32'd1);
        check_val("a5_valid",     32'(valid),            32'd1);
        check_val("a5_data",      32'(data),             32'hA5);
        check_val("a5_intr_cnt",  32'(intr_cnt - base),  32'd1);
        check_val("a5_frame_err", 32'(frame_err),        32'd0);
        pop();
        check_val("a5_valid_after_rd", 32'(valid), 32'd0);

        // Five back-to-back bytes into a four-deep FIFO
        base = intr_cnt;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        cycles(2);
        check_val("ovf_full",     32'(full),            32'd1);
        check_val("ovf_overrun",  32'(overrun),         32'd1);
        check_val("ovf_intr_cnt", 32'(intr_cnt - base), 32'd4);
        for (int b = 1; b <= 4; b++) begin
            check_val("ovf_pop_data", 32'(data), 32'(b));
            pop();
        end
        check_val("ovf_empty_valid",  32'(valid),   32'd0);
        check_val("ovf_empty_full",   32'(full),    32'd0);
        check_val("ovf_still_sticky", 32'(overrun), 32'd1);
        pulse_clr();
        check_val("ovf_clr", 32'(overrun), 32'd0);

        // Bad stop bit followed by a held-low break
        base = intr_cnt;
        send_frame(8'h3C, 1'b0);
        cycles(100);
        Rx = 1'b1;
        cycles(20);
        check_val("brk_frame_err", 32'(frame_err),        32'd1);
        check_val("brk_valid",     32'(valid),            32'd0);
        check_val("brk_intr_cnt",  32'(intr_cnt - base),  32'd0);
        send_frame(8'h3C, 1'b1);
        cycles(2);
        check_val("brk_next_valid", 32'(valid),           32'd1);
        check_val("brk_next_data",  32'(data),            32'h3C);
        check_val("brk_next_intr",  32'(intr_cnt - base), 32'd1);
        pop();
        pulse_clr();
        check_val("brk_clr", 32'(frame_err), 32'd0);

        // Short low glitch rejected
        base = intr_cnt;
        Rx = 1'b0;
        cycles(4);
        Rx = 1'b1;
        cycles(3 * CPB);
        check_val("glitch_valid",     32'(valid),            32'd0);
        check_val("glitch_frame_err", 32'(frame_err),        32'd0);
        check_val("glitch_overrun",   32'(overrun),          32'd0);
        check_val("glitch_intr_cnt",  32'(intr_cnt - base),  32'd0);

        // Reset in the middle of data bit 4 of frame 0xF5
        send_frame(8'h11, 1'b1);
        cycles(2);
        check_val("midrst_pre_valid", 32'(valid), 32'd1);
        Rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            Rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            cycles(CPB);
        end
        Rx = 1'b1;
        cycles(8);
        RST = 1'b1;
        cycles(2);
        check_reset_state("midrst");
        RST  = 1'b0;
        base = intr_cnt;
        cycles(5 * CPB);
        check_val("midrst_tail_valid", 32'(valid),           32'd0);
        check_val("midrst_tail_intr",  32'(intr_cnt - base), 32'd0);
        send_frame(8'h5A, 1'b1);
        cycles(2);
        check_val("midrst_next_valid", 32'(valid), 32'd1);
        check_val("midrst_next_data",  32'(data),  32'h5A);
        pop();

        // Full FIFO with rd on the push edge of 0x77
        base = intr_cnt;
        for (int b = 0; b < 4; b++) send_frame(8'hA1 + 8'(b), 1'b1);
        cycles(2);
        check_val("same_pre_full", 32'(full), 32'd1);
        fork
            send_frame(8'h77, 1'b1);
            begin
                cycles(PUSH_NEG);
                rd = 1'b1;
                cycles(1);
                rd = 1'b0;
            end
        join
        cycles(2);
        check_val("same_full",     32'(full),            32'd1);
        check_val("same_overrun",  32'(overrun),         32'd0);
        check_val("same_intr_cnt", 32'(intr_cnt - base), 32'd5);
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'h77};
        foreach (exp_q[i]) begin
            check_val("same_pop_data", 32'(data), 32'(exp_q[i]));
            pop();
        end
        check_val("same_empty_valid", 32'(valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver, the receive-side counterpart of the existing UART transmitter on the board's Tx pin.
- Deserializes 8N1 frames from an asynchronous Rx pin into a small first-word-fall-through FIFO.
- Exposes byte/valid/status to the MMIO IOBUS decode in the wrapper.
- Pulses an interrupt per received byte so it can be OR'd into the MCU interrupt.

Parameters:
- CLKS_PER_BIT, 868, CLK cycles per bit (100 MHz / 115200); must be >= 8.
- FIFO_DEPTH, 4, received-byte buffer entries; power of two, >= 2.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- Rx  in  1  asynchronous serial input; idle high.
- rd  in  1  pop strobe, one cycle; removes the head byte.
- clr  in  1  clears the sticky error flags.
- data  out  8  FIFO head byte; valid only when `valid` = 1.
- valid  out  1  FIFO not empty.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- overrun  out  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: stop bit sampled low.
- intr  out  1  one-cycle pulse when a byte is pushed.

Behaviour:
- Interface fixed: one clock, CLK. Reset is synchronous and active-high, RST.
- Synchronizer: Rx passes through 2 flops (rxs). Both flops reset to 1.
- Reset values:
  - state IDLE; FIFO empty.
  - valid=0, full=0, overrun=0, frame_err=0, intr=0, data=0.
  - All counters 0.
  - RST mid-frame aborts the frame; no partial byte is pushed.
- Bit counter cnt: 0..CLKS_PER_BIT-1. Bit index idx: 0..7.
- FSM:
  - IDLE: rxs=0 -> START, cnt=0.
  - START: counts to CLKS_PER_BIT/2-1 (integer divide), then samples rxs.
    - rxs=0 -> DATA, cnt=0, idx=0.
    - rxs=1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: at cnt=CLKS_PER_BIT-1, shift rxs into the shift register LSB-first, cnt=0, idx++.
    - After the idx=7 sample -> STOP.
  - STOP: at cnt=CLKS_PER_BIT-1, sample rxs.
    - rxs=1 -> push the byte and go IDLE.
    - rxs=0 -> set frame_err, discard the byte, go BRK.
  - BRK: wait for rxs=1 -> IDLE. A held-low line (break) never retriggers a frame.
- Push:
  - Write occurs on the stop-sample edge. valid rises and intr pulses the following cycle.
  - If full and rd=0: byte dropped, overrun set, intr not pulsed.
  - If full and rd=1 in the same cycle: pop and push both occur, no overrun, count unchanged.
- Pop:
  - rd with valid=1 advances the head. data shows the next byte (or stale, with valid=0) the next cycle.
  - rd with valid=0 is ignored; no underflow, pointers unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy count is 0..FIFO_DEPTH. full = (count==FIFO_DEPTH).
- Sticky flags: cleared by clr. If a set event and clr coincide, set wins.
- Latency: falling edge at Rx pin to valid high is at most 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 CLK cycles.
- Back-to-back frames: a new start bit is accepted the cycle after STOP returns to IDLE. No idle bit is required beyond the stop bit.
- The wrapper maps `data`/`valid` onto a read address. `rd` is the decoded read-strobe of that address, asserted one cycle per MCU load.

Test Plan:
- CLKS_PER_BIT=16. Send 0xA5 as 8N1 -> valid=1, data=0xA5, one intr pulse, frame_err=0, within the latency bound; rd -> valid=0 next cycle.
- Send 0x01,0x02,0x03,0x04,0x05 back-to-back with no rd:
  - FIFO holds 0x01..0x04, full=1, overrun=1, exactly 4 intr pulses.
  - 4 rd pops return 0x01..0x04 in order.
  - clr -> overrun=0.
- Frame 0x3C with stop bit low, then line held low 100 cycles, then high:
  - frame_err=1, FIFO stays empty, no intr.
  - A following valid 0x3C is received correctly.
- Rx low pulse of 4 cycles (shorter than half a bit) -> FSM returns to IDLE; no push, no flags.
- RST asserted during DATA bit 4 of a frame -> all outputs return to reset values. The remainder of that frame produces no push, at most frame_err. The next full frame 0x5A is received.
- FIFO full with rd asserted on the push cycle of a new byte 0x77 -> count stays 4, overrun=0, 0x77 emerges after the three older bytes.
